// File: rtl/hack_boot_loader.sv
// Hack CPU boot loader: receives a framed instruction image over a byte
// stream, writes it into instruction ROM, answers ACK/NAK, then releases
// the CPU. With boot_en low at reset release the CPU runs the preloaded ROM.
module hack_boot_loader #(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int MAX_WORDS      = 32768
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        boot_en,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        rom_we,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_wdata,
  output logic        cpu_reset_n_o,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [7:0]  ACK_BYTE  = 8'h06;
  localparam logic [7:0]  NAK_BYTE  = 8'h15;
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] MAX_N     = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE, CNT_H, CNT_L, DATA_H, DATA_L, CHK, RESP, RUN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [14:0] idx_q, idx_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rom_we_q, rom_we_d;
  logic [14:0] rom_addr_q, rom_addr_d;
  logic [15:0] rom_wdata_q, rom_wdata_d;
  logic        error_q, error_d;
  logic        first_q;

  logic        timer_run;
  logic        timeout;
  logic [15:0] n_word;

  // Inter-byte timer only runs while a frame is being received.
  assign timer_run = (state_q == CNT_H) || (state_q == CNT_L) ||
                     (state_q == DATA_H) || (state_q == DATA_L) ||
                     (state_q == CHK);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout   = timer_run && !rx_valid && (timer_q == TO_LAST);

  // Next-state, datapath and response selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    csum_d      = csum_q;
    tx_data_d   = tx_data_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    error_d     = error_q;
    n_word      = {cnt_q[15:8], rx_data};
    timer_d     = (timer_run && !rx_valid && !timeout) ? timer_q + 32'd1 : 32'd0;

    case (state_q)
      IDLE: begin
        if (first_q && !boot_en) begin
          state_d = RUN;
        end else if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = CNT_H;
          csum_d  = 8'h00;
          idx_d   = 15'd0;
          error_d = 1'b0;
        end
      end
      CNT_H: begin
        if (rx_valid) begin
          cnt_d   = {rx_data, 8'h00};
          csum_d  = csum_q ^ rx_data;
          state_d = CNT_L;
        end
      end
      CNT_L: begin
        if (rx_valid) begin
          cnt_d  = n_word;
          csum_d = csum_q ^ rx_data;
          if (n_word == 16'd0 || {1'b0, n_word} > MAX_N) begin
            state_d   = RESP;
            tx_data_d = NAK_BYTE;
          end else begin
            state_d = DATA_H;
          end
        end
      end
      DATA_H: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = DATA_L;
        end
      end
      DATA_L: begin
        if (rx_valid) begin
          rom_we_d    = 1'b1;
          rom_addr_d  = idx_q;
          rom_wdata_d = {hi_q, rx_data};
          csum_d      = csum_q ^ rx_data;
          idx_d       = idx_q + 15'd1;
          state_d     = (({1'b0, idx_q} + 16'd1) == cnt_q) ? CHK : DATA_H;
        end
      end
      CHK: begin
        if (rx_valid) begin
          tx_data_d = (rx_data == csum_q) ? ACK_BYTE : NAK_BYTE;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (tx_ready) begin
          if (tx_data_q == ACK_BYTE) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
            error_d = 1'b1;
          end
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    // Timeout abandons the frame; words already written stay in ROM.
    if (timeout) begin
      state_d   = RESP;
      tx_data_d = NAK_BYTE;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      timer_q     <= '0;
      tx_data_q   <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      error_q     <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      timer_q     <= timer_d;
      tx_data_q   <= tx_data_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      error_q     <= error_d;
      first_q     <= 1'b0;
    end
  end

  assign tx_valid      = (state_q == RESP);
  assign tx_data       = tx_data_q;
  assign rom_we        = rom_we_q;
  assign rom_addr      = rom_addr_q;
  assign rom_wdata     = rom_wdata_q;
  assign cpu_reset_n_o = (state_q == RUN);
  assign done          = (state_q == RUN);
  assign busy          = timer_run || (state_q == RESP);
  assign error         = error_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed testbench for hack_boot_loader with a short timeout.
module tb_hack_boot_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset_n, boot_en, rx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        tx_valid, rom_we, cpu_reset_n_o, busy, done, error;
  logic [7:0]  tx_data;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;

  int total = 0;
  int bad   = 0;

  int          wr_cnt = 0;
  logic [14:0] wr_addr [0:63];
  logic [15:0] wr_data [0:63];

  logic [44:0] all_outs;
  assign all_outs = {tx_valid, tx_data, rom_we, rom_addr, rom_wdata,
                     cpu_reset_n_o, busy, done, error};

  hack_boot_loader #(.TIMEOUT_CYCLES(TO), .MAX_WORDS(32768)) dut (
    .clk(clk), .reset_n(reset_n), .boot_en(boot_en),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_reset_n_o(cpu_reset_n_o), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every ROM write seen on the bus.
  always @(negedge clk) begin
    if (rom_we && wr_cnt < 64) begin
      wr_addr[wr_cnt] = rom_addr;
      wr_data[wr_cnt] = rom_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    $display("rx byte 0x%02h", b);
  endtask

  task do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task release_reset(input logic boot);
    boot_en = boot;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task handshake();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    $display("tx handshake done");
  endtask

  task test_reset();
    do_reset();
    total++;
    if (all_outs !== 45'd0) begin
      bad++; $display("FAIL reset_outs got=%h want=0", all_outs);
    end
  endtask

  task test_direct_run();
    int base;
    do_reset();
    base = wr_cnt;
    release_reset(1'b0);
    total++;
    if ({cpu_reset_n_o, done, busy} !== 3'b110) begin
      bad++; $display("FAIL direct_run cpu/done/busy got=%b want=110", {cpu_reset_n_o, done, busy});
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    total++;
    if ({tx_valid, done, cpu_reset_n_o} !== 3'b011 || wr_cnt != base) begin
      bad++; $display("FAIL direct_run_ignore got=%b writes=%0d want=011 writes=0",
                      {tx_valid, done, cpu_reset_n_o}, wr_cnt - base);
    end
  endtask

  task test_good_frame();
    int base;
    do_reset();
    release_reset(1'b1);
    base = wr_cnt;
    total++;
    if ({cpu_reset_n_o, done, busy} !== 3'b000) begin
      bad++; $display("FAIL idle_status got=%b want=000", {cpu_reset_n_o, done, busy});
    end
    send_byte(8'hA5);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL sync_busy got=%b want=1", busy); end
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    total++;
    if (rom_we !== 1'b0) begin bad++; $display("FAIL early_we got=%b want=0", rom_we); end
    send_byte(8'h34);
    total++;
    if ({rom_we, rom_addr, rom_wdata} !== {1'b1, 15'd0, 16'h1234}) begin
      bad++; $display("FAIL write0 got=%b/%h/%h want=1/0000/1234", rom_we, rom_addr, rom_wdata);
    end
    send_byte(8'hAB); send_byte(8'hCD);
    total++;
    if ({rom_we, rom_addr, rom_wdata} !== {1'b1, 15'd1, 16'hABCD}) begin
      bad++; $display("FAIL write1 got=%b/%h/%h want=1/0001/abcd", rom_we, rom_addr, rom_wdata);
    end
    send_byte(8'h42);
    total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h06}) begin
      bad++; $display("FAIL ack got=%b/%h want=1/06", tx_valid, tx_data);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({tx_valid, tx_data, cpu_reset_n_o} !== {1'b1, 8'h06, 1'b0}) begin
      bad++; $display("FAIL ack_hold got=%b/%h/%b want=1/06/0", tx_valid, tx_data, cpu_reset_n_o);
    end
    handshake();
    total++;
    if ({tx_valid, cpu_reset_n_o, done, busy, error} !== 5'b01100 || wr_cnt - base != 2) begin
      bad++; $display("FAIL ack_run got=%b writes=%0d want=01100 writes=2",
                      {tx_valid, cpu_reset_n_o, done, busy, error}, wr_cnt - base);
    end
  endtask

  task test_bad_checksum();
    int base;
    do_reset();
    release_reset(1'b1);
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h43);
    total++;
    if (wr_cnt - base != 2 || wr_addr[base+1] !== 15'd1 || wr_data[base+1] !== 16'hABCD) begin
      bad++; $display("FAIL badcs_writes got=%0d want=2 with addr1=abcd", wr_cnt - base);
    end
    total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h15}) begin
      bad++; $display("FAIL badcs_nak got=%b/%h want=1/15", tx_valid, tx_data);
    end
    handshake();
    total++;
    if ({error, cpu_reset_n_o, done, busy, tx_valid} !== 5'b10000) begin
      bad++; $display("FAIL badcs_idle got=%b want=10000", {error, cpu_reset_n_o, done, busy, tx_valid});
    end
    send_byte(8'hA5);
    total++;
    if ({error, busy} !== 2'b01) begin
      bad++; $display("FAIL error_clear got=%b want=01", {error, busy});
    end
  endtask

  task test_bad_count();
    int base;
    do_reset();
    release_reset(1'b1);
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h15}) begin
      bad++; $display("FAIL zero_count got=%b/%h want=1/15", tx_valid, tx_data);
    end
    handshake();
    total++;
    if ({error, busy} !== 2'b10) begin
      bad++; $display("FAIL zero_count_err got=%b want=10", {error, busy});
    end
    send_byte(8'hA5); send_byte(8'h80); send_byte(8'h01);
    total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h15} || wr_cnt != base) begin
      bad++; $display("FAIL big_count got=%b/%h writes=%0d want=1/15 writes=0",
                      tx_valid, tx_data, wr_cnt - base);
    end
    handshake();
    send_byte(8'hA5); send_byte(8'h80); send_byte(8'h00);
    total++;
    if ({tx_valid, busy} !== 2'b01) begin
      bad++; $display("FAIL max_count got=%b want=01", {tx_valid, busy});
    end
  endtask

  task test_timeout();
    int  base;
    logic early, stable;
    do_reset();
    release_reset(1'b1);
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    early = 1'b0;
    repeat (TO - 1) begin
      @(negedge clk);
      if (tx_valid) early = 1'b1;
    end
    total++;
    if (early !== 1'b0) begin bad++; $display("FAIL timeout_early got=1 want=0"); end
    @(negedge clk);
    total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h15}) begin
      bad++; $display("FAIL timeout_nak got=%b/%h want=1/15", tx_valid, tx_data);
    end
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if ({tx_valid, tx_data} !== {1'b1, 8'h15}) stable = 1'b0;
    end
    total++;
    if (stable !== 1'b1) begin bad++; $display("FAIL resp_stable got=0 want=1"); end
    send_byte(8'hA5);
    total++;
    if ({tx_valid, tx_data, busy} !== {1'b1, 8'h15, 1'b1} || wr_cnt != base) begin
      bad++; $display("FAIL resp_ignore_rx got=%b/%h/%b writes=%0d want=1/15/1 writes=0",
                      tx_valid, tx_data, busy, wr_cnt - base);
    end
    handshake();
    total++;
    if ({error, tx_valid, cpu_reset_n_o} !== 3'b100) begin
      bad++; $display("FAIL timeout_err got=%b want=100", {error, tx_valid, cpu_reset_n_o});
    end
  endtask

  task test_reset_midframe();
    int base;
    do_reset();
    release_reset(1'b1);
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({rom_we, tx_valid, busy, rom_addr, rom_wdata} !== 34'd0) begin
      bad++; $display("FAIL midframe_reset got=%b/%b/%b/%h/%h want=all zero",
                      rom_we, tx_valid, busy, rom_addr, rom_wdata);
    end
    rx_valid = 1'b1; rx_data = 8'hCD;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    total++;
    if (wr_cnt - base != 1) begin
      bad++; $display("FAIL midframe_writes got=%0d want=1", wr_cnt - base);
    end
    release_reset(1'b1);
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h50);
    total++;
    if (wr_cnt - base != 1 || wr_addr[base] !== 15'd0 || wr_data[base] !== 16'hBEEF) begin
      bad++; $display("FAIL reload_write got=%0d writes want=1 write 0000=beef", wr_cnt - base);
    end
    total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h06}) begin
      bad++; $display("FAIL reload_ack got=%b/%h want=1/06", tx_valid, tx_data);
    end
    handshake();
  endtask

  task test_back_to_back();
    int base;
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h32);
    total++;
    if ({tx_valid, done, cpu_reset_n_o, busy} !== 4'b0110 || wr_cnt != base) begin
      bad++; $display("FAIL run_ignore got=%b writes=%0d want=0110 writes=0",
                      {tx_valid, done, cpu_reset_n_o, busy}, wr_cnt - base);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    boot_en  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    test_reset();
    test_direct_run();
    test_good_frame();
    test_bad_checksum();
    test_bad_count();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
